// File: rtl/writeback_buffer.sv
// Writeback buffer: a circular FIFO of evicted cache lines that drains to memory one word at a time.
// Pushes coalesce into pending entries, and lookups let the cache read data that is still buffered.
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evict,
    input  logic [31:0]      evict_address,
    input  logic [31:0]      evict_data,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    input  logic             mem_ack,
    input  logic [31:0]      lookup_address,
    output logic             lookup_hit,
    output logic [31:0]      lookup_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_address_q, mem_address_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             overflow_q, overflow_d;

    logic             full_w;
    logic             pop;
    logic             coal_hit;
    logic [PTR_W-1:0] coal_idx;
    logic             push;
    logic             drop;

    assign full_w = (count_q == CNT_W'(DEPTH));
    assign pop    = (state_q == S_WRITE) && mem_ack;

    // Scan oldest to youngest so the youngest match wins; the entry on the bus is excluded.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == evict_address)
                && !(mem_write_q && (i == 0))) begin
                coal_hit = 1'b1;
                coal_idx = head_q + PTR_W'(i);
            end
        end
    end

    assign push = evict && !coal_hit && (!full_w || pop);
    assign drop = evict && !coal_hit && full_w && !pop;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (evict && coal_hit) begin
            data_d[coal_idx] = evict_data;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = evict_address;
            data_d[tail_q]  = evict_data;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // The bus is loaded from post-update storage, so same-edge coalesces and pushes are forwarded.
    always_comb begin
        state_d       = state_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        overflow_d    = overflow_q | drop;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d       = S_WRITE;
                    mem_write_d   = 1'b1;
                    mem_address_d = addr_d[head_d];
                    mem_data_d    = data_d[head_d];
                end
            end
            default: begin
                if (pop) begin
                    if (count_d != '0) begin
                        mem_address_d = addr_d[head_d];
                        mem_data_d    = data_d[head_d];
                    end else begin
                        state_d     = S_IDLE;
                        mem_write_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            state_q       <= state_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == lookup_address)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[head_q + PTR_W'(i)];
            end
        end
    end

    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_data_q;
    assign count          = count_q;
    assign full           = full_w;
    assign empty          = (count_q == '0);
    assign overflow       = overflow_q;

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(DEPTH)+1, giving the width of the occupancy count.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-high).
REQ-004 The block SHALL have the following write-side ports: evict input 1 (one-cycle push strobe from the cache); evict_address input 32 (victim address); evict_data input 32 (victim word).
REQ-005 The block SHALL have the following memory-side ports: mem_write output 1 (write request); mem_address output 32; mem_write_data output 32; mem_ack input 1 (memory accepted the write).
REQ-006 The block SHALL have the following lookup ports: lookup_address input 32; lookup_hit output 1; lookup_data output 32.
REQ-007 The block SHALL have the following status ports: full output 1; empty output 1; count output CNT_W; overflow output 1 (sticky).

Function
REQ-008 Storage SHALL be a circular FIFO of DEPTH entries, each holding {valid, address[31:0], data[31:0]}, with head and tail pointers that wrap modulo DEPTH.
REQ-009 Push: when evict is high at a rising edge and no coalesce occurs, the entry SHALL be written at tail, tail SHALL advance, and count SHALL increment.
REQ-010 Coalesce: if evict_address equals the address of a valid entry that is not currently being driven on the memory bus, that entry's data SHALL be overwritten with evict_data, and count and tail SHALL be unchanged.
REQ-011 The entry at head SHALL NOT be coalesced while mem_write is high; such a push SHALL append a new entry instead.
REQ-012 The drain FSM SHALL have exactly two states, IDLE and WRITE, with registered outputs.
REQ-013 In IDLE with count nonzero at a rising edge, the FSM SHALL move to WRITE, assert mem_write, and load mem_address and mem_write_data from head.
REQ-014 In WRITE, mem_write, mem_address and mem_write_data SHALL hold stable until a rising edge that samples mem_ack high.
REQ-015 On that mem_ack edge, the head entry SHALL be popped (valid cleared, head advanced, count decremented); if entries remain, the FSM SHALL stay in WRITE and present the next head on the following cycle; otherwise it SHALL return to IDLE and deassert mem_write.
REQ-016 mem_ack sampled while in IDLE SHALL be ignored.
REQ-017 Latency: evict at edge k SHALL cause mem_write to be high after edge k+1 when the buffer was empty and IDLE.
REQ-018 A simultaneous push and pop in the same edge SHALL leave count unchanged, and when full a push SHALL be accepted if a pop occurs in that same edge.
REQ-019 Overflow: a push while full, with no pop that edge and no coalesce, SHALL be dropped, SHALL leave the contents unchanged, and SHALL set overflow to 1 until reset.
REQ-020 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both combinational from count.
REQ-021 lookup_hit SHALL be combinational and high if any valid entry's address equals lookup_address, including the head entry while in flight.
REQ-022 lookup_data SHALL return the data of the youngest matching entry, and SHALL be 0 when lookup_hit is 0.
REQ-023 Lookup SHALL reflect register state only, so a same-cycle push SHALL NOT be visible to lookup until after the edge.

Reset
REQ-024 Reset assertion SHALL asynchronously clear all valid bits, head, tail and count, and set the FSM to IDLE.
REQ-025 Reset assertion SHALL drive mem_write=0, mem_address=0, mem_write_data=0, overflow=0, lookup_hit=0 and lookup_data=0, giving empty=1 and full=0.
REQ-026 Reset asserted mid-write SHALL abandon the in-flight write, and mem_write SHALL drop immediately.

Verification
REQ-027 Single push: evict of addr 0x1000/data 0xAAAA, with mem_ack held high, SHALL give mem_write=1 with 0x1000/0xAAAA one cycle later, a pop on the next edge, and then empty=1 with mem_write=0.
REQ-028 Fill with mem_ack=0: 4 evicts (0x100, 0x140, 0x180, 0x1C0) SHALL give full=1; a 5th evict (0x200) SHALL give overflow=1 with count still 4, and the drain SHALL then emit the addresses in order 0x100..0x1C0.
REQ-029 Coalesce: evicts 0x40/0x11 and 0x80/0x22 with mem_ack=0, followed by evict 0x80/0x33, SHALL leave count=2 and make lookup 0x80 return hit=1, data=0x33.
REQ-030 In-flight guard: with head 0x40 on the bus, evict 0x40/0x55 SHALL append a new entry (count increments), drain SHALL write 0x40 twice (old data, then 0x55), and lookup 0x40 SHALL return 0x55.
REQ-031 Full with simultaneous push+pop: at full, evict together with mem_ack SHALL keep count=4 with overflow=0.
REQ-032 Reset mid-write: asserting reset while mem_write=1 SHALL give mem_write=0, count=0, empty=1 asynchronously, with no write emitted after release.
